inst_cache: RTL
===============

# inst_cache

Direct-mapped, one-word-per-line instruction cache between the instruction-fetch unit and the memory controller's iCache port. Hits return in one cycle. On a miss, the block drives a word read request to the memory controller. It drops the request on the controller's early `is_returning` warning, then fills the line and forwards the word to fetch. Only one fetch is outstanding at a time. A pipeline clear drops the pending response.

## Interface
- `INDEX_BITS`, default 5: line count is 2^INDEX_BITS. Index is `addr[INDEX_BITS+1:2]`. Tag is `addr[31:INDEX_BITS+2]`.
- `clk_in` input 1: the single clock.
- `rst_in` input 1: reset, asynchronous and active-low.
- `rdy_in` input 1: when low, all state and outputs hold.
- `clear_in` input 1: pipeline flush.
- `if2iCache_enable` input 1: one-cycle fetch request pulse. It is legal only while `iCache2if_ready`=1.
- `if2iCache_addr` input 32: fetch address. Bits [1:0] are ignored.
- `iCache2if_ready` output 1: high exactly when the FSM is in IDLE.
- `iCache2if_enable` output 1: one-cycle response pulse.
- `iCache2if_inst` output 32: instruction word, valid with `iCache2if_enable`.
- `iCache2memCon_enable` output 1: level read request to the memory controller.
- `iCache2memCon_address` output 32: word-aligned miss address.
- `memCon2iCache_is_returning` input 1: early warning that data arrives two cycles later.
- `memCon2iCache_enable` input 1: one-cycle data-valid pulse.
- `memCon2iCache_return` input 32: fill word.

## Operation
- Storage per line: valid bit, tag, and 32-bit data. Registers hold the latched address and a `discard` flag.
- The FSM has three states: IDLE, REQ and FILL.
- **IDLE**, `if2iCache_enable`=1 and `clear_in`=0:
  - Latch the address and look up its index.
  - On a hit, drive `iCache2if_enable`=1 and `iCache2if_inst`=data on the next edge, and stay in IDLE.
  - On a miss, set `iCache2memCon_enable`=1 and `iCache2memCon_address`={addr[31:2],2'b00} on the next edge, then go to REQ.
- **REQ**: on sampling `memCon2iCache_is_returning`=1, deassert `iCache2memCon_enable` at the next edge and go to FILL. The request is never held into the controller's idle cycle, so no duplicate fetch is issued.
- **REQ, `memCon2iCache_enable` without a prior `is_returning`**: this is a protocol error. Treat it as FILL completion and deassert the request.
- **FILL**, on `memCon2iCache_enable`=1:
  - Write the line: valid=1, tag, and data=`memCon2iCache_return`.
  - If `discard`=0 and `clear_in`=0, pulse `iCache2if_enable` with that word on the next edge.
  - Clear `discard` and go to IDLE.
- **`clear_in`=1**:
  - In IDLE: ignore a same-cycle request and suppress any response not yet registered.
  - In REQ or FILL: set `discard`. The fill completes and writes the array, because the memory controller cannot abort a transfer. No response is sent to fetch.
- Requests that arrive outside IDLE are ignored; asserting one is a fetch-side protocol error.
- Only one outstanding miss is allowed, and there is no hit-under-miss.

## Timing
- Reset (`rst_in`=0), applied immediately and asynchronously:
  - All valid bits are 0 and the state is IDLE.
  - `iCache2if_ready`=1.
  - `iCache2if_enable`, `iCache2if_inst`, `iCache2memCon_enable`, `iCache2memCon_address` and `discard` are all 0.
- Reset mid-miss abandons the transfer. The memory controller is reset on the same reset network.
- Hit latency: request at edge T, response at edge T+1. `iCache2if_ready` stays 1.
- Miss latency:
  - Request asserted at T+1.
  - Memory controller data pulse at or after T+6 (five-byte-cycle sequence, plus any LSU priority stall).
  - Response one edge after the data pulse.
- `iCache2if_enable` is high for exactly one cycle per accepted, non-discarded request.
- `iCache2if_ready` drops at the edge that enters REQ and rises at the edge that returns to IDLE. Fetch may issue in the same cycle the response pulse is seen.
- `rdy_in`=0 freezes everything, including pulse outputs. Pulses resume and complete when `rdy_in` returns.
- Clear and a data pulse in the same cycle: the array is written and the response is suppressed.

## Test plan
- **Reset, then cold miss**: reset, then fetch 0x100.
  - `iCache2memCon_address`=0x100.
  - Model returns 0x00000013.
  - One cycle after the data pulse, `iCache2if_inst`=0x13 with a single-cycle `iCache2if_enable`.
- **Hit**: fetch 0x100 again.
  - Response at the next edge.
  - `iCache2memCon_enable` never rises.
- **Conflict**: fetch 0x180, which shares index 0 with 0x100 (model word 0xDEADBEEF).
  - Miss and replacement.
  - Refetching 0x100 misses again.
- **Handshake**: the memory controller model counts accepted requests.
  - The request deasserts one edge after `is_returning`.
  - Exactly 1 transfer per miss across 20 back-to-back misses interleaved with LSU-priority stalls.
- **Clear**: pulse `clear_in` during FILL.
  - No `iCache2if_enable`.
  - A following fetch to the same address hits with the filled word.
  - `clear_in` together with a request in IDLE produces no request and no response.
- **Reset and stall**:
  - Drop `rst_in` mid-REQ: outputs go to 0 without a clock edge, and a refetch misses.
  - Hold `rdy_in`=0 across a response edge: the pulse is delayed, not lost.

Source files
------------

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch unit
// and the memory controller's iCache port. Single outstanding miss, no hit-under-miss.
module inst_cache #(
  parameter int unsigned INDEX_BITS = 5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        if2iCache_enable,
  input  logic [31:0] if2iCache_addr,
  output logic        iCache2if_ready,
  output logic        iCache2if_enable,
  output logic [31:0] iCache2if_inst,
  output logic        iCache2memCon_enable,
  output logic [31:0] iCache2memCon_address,
  input  logic        memCon2iCache_is_returning,
  input  logic        memCon2iCache_enable,
  input  logic [31:0] memCon2iCache_return
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 32 - INDEX_BITS - 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [29:0]            addr_q, addr_d;
  logic                   discard_q, discard_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [31:0]            data_q [LINES];
  logic                   if_en_q, if_en_d;
  logic [31:0]            if_inst_q, if_inst_d;
  logic                   mem_en_q, mem_en_d;
  logic [31:0]            mem_addr_q, mem_addr_d;

  logic                   fill_we;
  logic                   hit;
  logic [INDEX_BITS-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]       req_tag, fill_tag;

  assign req_idx  = if2iCache_addr[INDEX_BITS+1:2];
  assign req_tag  = if2iCache_addr[31:INDEX_BITS+2];
  assign fill_idx = addr_q[INDEX_BITS-1:0];
  assign fill_tag = addr_q[29:INDEX_BITS];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    discard_d  = discard_q;
    valid_d    = valid_q;
    if_en_d    = 1'b0;
    if_inst_d  = if_inst_q;
    mem_en_d   = mem_en_q;
    mem_addr_d = mem_addr_q;
    fill_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if2iCache_enable && !clear_in) begin
          addr_d = if2iCache_addr[31:2];
          if (hit) begin
            if_en_d   = 1'b1;
            if_inst_d = data_q[req_idx];
          end else begin
            mem_en_d   = 1'b1;
            mem_addr_d = if2iCache_addr & ~32'h3;
            state_d    = S_REQ;
          end
        end
      end
      S_REQ, S_FILL: begin
        if (clear_in) discard_d = 1'b1;
        // A data pulse in REQ (no prior warning) completes the fill the same way.
        if (memCon2iCache_enable) begin
          fill_we           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          mem_en_d          = 1'b0;
          if (!discard_q && !clear_in) begin
            if_en_d   = 1'b1;
            if_inst_d = memCon2iCache_return;
          end
          discard_d = 1'b0;
          state_d   = S_IDLE;
        end else if (state_q == S_REQ && memCon2iCache_is_returning) begin
          mem_en_d = 1'b0;
          state_d  = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      discard_q  <= 1'b0;
      valid_q    <= '0;
      if_en_q    <= 1'b0;
      if_inst_q  <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      discard_q  <= discard_d;
      valid_q    <= valid_d;
      if_en_q    <= if_en_d;
      if_inst_q  <= if_inst_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Tag/data need no reset: a line is only ever read behind its valid bit.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= memCon2iCache_return;
    end
  end

  assign iCache2if_ready       = (state_q == S_IDLE);
  assign iCache2if_enable      = if_en_q;
  assign iCache2if_inst        = if_inst_q;
  assign iCache2memCon_enable  = mem_en_q;
  assign iCache2memCon_address = mem_addr_q;

endmodule
